// File: rtl/sccb_arbiter.sv
// sccb_arbiter: round-robin sharing of one SCCB write engine between the
// power-up setup sequencer (port 0) and the runtime control port (port 1).
// It issues a one-cycle start pulse, follows the engine's ready handshake,
// acknowledges the owning port, and aborts a hung engine with a watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner; grant when the engine is ready and a port requests
// WAIT_BUSY | start issued, waiting for the engine to drop ready
// WAIT_DONE | engine busy, waiting for ready to return high
// ACK       | one-cycle ack (and err on timeout) to the owner, then release
module sccb_arbiter #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] sub_address0,
    input  logic [7:0] set_data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] sub_address1,
    input  logic [7:0] set_data1,
    output logic       ack1,
    output logic       err,
    output logic       busy,
    output logic [1:0] grant,
    output logic       sccb_start,
    output logic [7:0] sccb_sub_address,
    output logic [7:0] sccb_set_data,
    input  logic       sccb_ready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       grant_nxt;
    logic [7:0]       addr_nxt, data_nxt;
    logic             start_nxt, ack0_nxt, ack1_nxt, err_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             last_grant, last_grant_nxt;  // 1: port 1 was served last
    logic             win1;
    logic             timeout_hit;

    assign busy        = (state != IDLE);
    assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign timeout_hit = (cnt >= CNT_LAST);
    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    assign win1        = req1 && (!req0 || !last_grant);

    // State, handshake outputs, latched transaction and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            grant            <= 2'b00;
            sccb_start       <= 1'b0;
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            err              <= 1'b0;
            sccb_sub_address <= 8'h00;
            sccb_set_data    <= 8'h00;
            cnt              <= '0;
            last_grant       <= 1'b1;
        end else begin
            state            <= state_nxt;
            grant            <= grant_nxt;
            sccb_start       <= start_nxt;
            ack0             <= ack0_nxt;
            ack1             <= ack1_nxt;
            err              <= err_nxt;
            sccb_sub_address <= addr_nxt;
            sccb_set_data    <= data_nxt;
            cnt              <= cnt_nxt;
            last_grant       <= last_grant_nxt;
        end
    end

    // Next-state selection, arbitration and watchdog.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        addr_nxt       = sccb_sub_address;
        data_nxt       = sccb_set_data;
        start_nxt      = 1'b0;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        err_nxt        = 1'b0;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;

        case (state)
            IDLE: begin
                if (sccb_ready && (req0 || req1)) begin
                    grant_nxt = win1 ? 2'b10 : 2'b01;
                    addr_nxt  = win1 ? sub_address1 : sub_address0;
                    data_nxt  = win1 ? set_data1 : set_data0;
                    start_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                cnt_nxt = cnt_inc;
                if (!sccb_ready) begin
                    state_nxt = WAIT_DONE;
                end else if (timeout_hit) begin
                    ack0_nxt  = grant[0];
                    ack1_nxt  = grant[1];
                    err_nxt   = 1'b1;
                    state_nxt = ACK;
                end
            end
            WAIT_DONE: begin
                cnt_nxt = cnt_inc;
                if (sccb_ready || timeout_hit) begin
                    ack0_nxt  = grant[0];
                    ack1_nxt  = grant[1];
                    err_nxt   = !sccb_ready;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                last_grant_nxt = grant[1];
                grant_nxt      = 2'b00;
                state_nxt      = IDLE;
            end
            default: begin
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter: main instance with a behavioural engine
// model, second instance with a short watchdog and an engine that never
// drops ready.
module tb_sccb_arbiter;

    localparam int DONE_LAT = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] sub_address0 = 8'h00, set_data0 = 8'h00;
    logic [7:0] sub_address1 = 8'h00, set_data1 = 8'h00;
    logic       ack0, ack1, err, busy, sccb_start;
    logic [1:0] grant;
    logic [7:0] sccb_sub_address, sccb_set_data;
    logic       sccb_ready;
    logic       eng_auto = 1'b1;
    logic       man_ready = 1'b1;
    logic       eng_ready = 1'b1;
    int         eng_cnt = 0;

    logic       t_req0 = 1'b0, t_req1 = 1'b0, t_ready = 1'b1;
    logic [7:0] t_addr = 8'h33, t_data = 8'h44;
    logic       t_ack0, t_ack1, t_err, t_busy, t_start;
    logic [1:0] t_grant;
    logic [7:0] t_sub_address, t_set_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign sccb_ready = eng_auto ? eng_ready : man_ready;

    // Engine model: drop ready the cycle after start, raise it DONE_LAT cycles later.
    always @(posedge clk) begin
        if (!rst_n || !eng_auto) begin
            eng_ready <= 1'b1;
            eng_cnt   <= 0;
        end else if (sccb_start) begin
            eng_ready <= 1'b0;
            eng_cnt   <= DONE_LAT;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_ready <= 1'b1;
        end
    end

    sccb_arbiter dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .sub_address0(sub_address0), .set_data0(set_data0), .ack0(ack0),
        .req1(req1), .sub_address1(sub_address1), .set_data1(set_data1), .ack1(ack1),
        .err(err), .busy(busy), .grant(grant), .sccb_start(sccb_start),
        .sccb_sub_address(sccb_sub_address), .sccb_set_data(sccb_set_data),
        .sccb_ready(sccb_ready)
    );

    sccb_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .reset(rst_n),
        .req0(t_req0), .sub_address0(t_addr), .set_data0(t_data), .ack0(t_ack0),
        .req1(t_req1), .sub_address1(t_addr), .set_data1(t_data), .ack1(t_ack1),
        .err(t_err), .busy(t_busy), .grant(t_grant), .sccb_start(t_start),
        .sccb_sub_address(t_sub_address), .sccb_set_data(t_set_data),
        .sccb_ready(t_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; t_req0 = 1'b0; t_req1 = 1'b0;
        eng_auto = 1'b1; man_ready = 1'b1;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        n_checks++;
        if ({sccb_start, ack0, ack1, err, busy} !== 5'b0 || grant !== 2'b00 ||
            sccb_sub_address !== 8'h00 || sccb_set_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: start=%b ack0=%b ack1=%b err=%b busy=%b grant=%b addr=%h data=%h, required all zero",
                     sccb_start, ack0, ack1, err, busy, grant, sccb_sub_address, sccb_set_data);
        end
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b grant=%b, required 0/00", busy, grant);
        end
    endtask

    task automatic test_single_port0;
        int k = 0;
        int bad = 0;
        do_reset;
        req0 = 1'b1; sub_address0 = 8'h12; set_data0 = 8'h80;
        tick;
        n_checks++;
        if (sccb_start !== 1'b1 || grant !== 2'b01 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start: start=%b grant=%b busy=%b, required 1/01/1", sccb_start, grant, busy);
        end
        n_checks++;
        if (sccb_sub_address !== 8'h12 || sccb_set_data !== 8'h80) begin
            n_fail++;
            $display("FAIL single_latch: addr=%h data=%h, required 12/80", sccb_sub_address, sccb_set_data);
        end
        while (k < 60 && ack0 !== 1'b1) begin
            tick;
            k++;
            if (sccb_start !== 1'b0) bad++;
            if (sccb_sub_address !== 8'h12 || sccb_set_data !== 8'h80) bad++;
        end
        n_checks++;
        if (k !== 42) begin
            n_fail++;
            $display("FAIL single_ack_latency: ack0 after %0d cycles, required 42", k);
        end
        n_checks++;
        if (err !== 1'b0 || ack1 !== 1'b0 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ack_flags: err=%b ack1=%b grant=%b, required 0/0/01", err, ack1, grant);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL single_hold: %0d bad cycles (start or addr/data), required 0", bad);
        end
        req0 = 1'b0;
        tick;
        n_checks++;
        if (ack0 !== 1'b0 || busy !== 1'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL single_release: ack0=%b busy=%b grant=%b, required 0/0/00", ack0, busy, grant);
        end
    endtask

    task automatic test_tie;
        logic [1:0] exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset;
        req0 = 1'b1; req1 = 1'b1;
        sub_address0 = 8'h01; set_data0 = 8'h10;
        sub_address1 = 8'h02; set_data1 = 8'h20;
        for (int t = 0; t < 4; t++) begin
            int k = 0;
            tick;
            while (k < 10 && sccb_start !== 1'b1) begin tick; k++; end
            n_checks++;
            if (sccb_start !== 1'b1 || grant !== exp_grant[t]) begin
                n_fail++;
                $display("FAIL tie_grant[%0d]: start=%b grant=%b, required 1/%b", t, sccb_start, grant, exp_grant[t]);
            end
            n_checks++;
            if (sccb_sub_address !== (exp_grant[t][1] ? 8'h02 : 8'h01)) begin
                n_fail++;
                $display("FAIL tie_addr[%0d]: addr=%h", t, sccb_sub_address);
            end
            k = 0;
            while (k < 60 && (ack0 | ack1) !== 1'b1) begin tick; k++; end
            n_checks++;
            if ({ack1, ack0} !== exp_grant[t] || err !== 1'b0) begin
                n_fail++;
                $display("FAIL tie_ack[%0d]: ack1ack0=%b err=%b, required %b/0", t, {ack1, ack0}, err, exp_grant[t]);
            end
            tick;
            n_checks++;
            if ((ack0 | ack1 | sccb_start) !== 1'b0) begin
                n_fail++;
                $display("FAIL tie_gap[%0d]: ack0=%b ack1=%b start=%b in cycle after ack, required 0", t, ack0, ack1, sccb_start);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_not_ready;
        int bad = 0;
        do_reset;
        eng_auto = 1'b0;
        man_ready = 1'b0;
        req1 = 1'b1; sub_address1 = 8'h3A; set_data1 = 8'h07;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (sccb_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL not_ready_hold: %0d cycles with start or busy, required 0", bad);
        end
        man_ready = 1'b1;
        tick;
        n_checks++;
        if (sccb_start !== 1'b1 || grant !== 2'b10) begin
            n_fail++;
            $display("FAIL not_ready_start: start=%b grant=%b, required 1/10", sccb_start, grant);
        end
        man_ready = 1'b0;
        tick; tick;
        man_ready = 1'b1;
        tick;
        n_checks++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL not_ready_ack: ack1=%b ack0=%b err=%b, required 1/0/0", ack1, ack0, err);
        end
        req1 = 1'b0;
        tick;
        n_checks++;
        if (busy !== 1'b0 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL not_ready_release: busy=%b ack1=%b, required 0/0", busy, ack1);
        end
        eng_auto = 1'b1;
    endtask

    task automatic test_timeout;
        int k = 0;
        do_reset;
        t_req0 = 1'b1;
        tick;
        n_checks++;
        if (t_start !== 1'b1 || t_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_start: start=%b grant=%b, required 1/01", t_start, t_grant);
        end
        while (k < 40 && t_ack0 !== 1'b1) begin tick; k++; end
        n_checks++;
        if (k !== 16) begin
            n_fail++;
            $display("FAIL timeout_latency: ack0 after %0d cycles, required 16", k);
        end
        n_checks++;
        if (t_err !== 1'b1 || t_ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err: err=%b ack1=%b, required 1/0", t_err, t_ack1);
        end
        t_req0 = 1'b0;
        tick;
        n_checks++;
        if (t_busy !== 1'b0 || t_err !== 1'b0 || t_ack0 !== 1'b0 || t_grant !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_release: busy=%b err=%b ack0=%b grant=%b, required 0/0/0/00",
                     t_busy, t_err, t_ack0, t_grant);
        end
    endtask

    task automatic test_reset_mid;
        int k = 0;
        int bad = 0;
        do_reset;
        req1 = 1'b1; sub_address1 = 8'h66; set_data1 = 8'h77;
        tick;
        tick; tick; tick; tick;
        n_checks++;
        if (busy !== 1'b1 || grant !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_pre: busy=%b grant=%b, required 1/10", busy, grant);
        end
        #2;
        rst_n = 1'b0;
        req1 = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant !== 2'b00 || sccb_start !== 1'b0 || sccb_sub_address !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_async: busy=%b grant=%b start=%b addr=%h, required 0/00/0/00",
                     busy, grant, sccb_start, sccb_sub_address);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        tick;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_noack: %0d cycles with ack, required 0", bad);
        end
        req0 = 1'b1; req1 = 1'b1;
        tick;
        n_checks++;
        if (grant !== 2'b01 || sccb_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_tie: grant=%b start=%b, required 01/1", grant, sccb_start);
        end
        while (k < 60 && ack0 !== 1'b1) begin tick; k++; end
        req0 = 1'b0; req1 = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_input_change;
        int k = 0;
        int bad = 0;
        do_reset;
        req1 = 1'b1; sub_address1 = 8'h5A; set_data1 = 8'hC3;
        tick;
        n_checks++;
        if (grant !== 2'b10 || sccb_sub_address !== 8'h5A || sccb_set_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL change_latch: grant=%b addr=%h data=%h, required 10/5a/c3", grant, sccb_sub_address, sccb_set_data);
        end
        sub_address1 = 8'hA5; set_data1 = 8'h3C;
        while (k < 60 && ack1 !== 1'b1) begin
            tick;
            k++;
            if (sccb_sub_address !== 8'h5A || sccb_set_data !== 8'hC3) bad++;
        end
        n_checks++;
        if (ack1 !== 1'b1 || bad !== 0) begin
            n_fail++;
            $display("FAIL change_hold: ack1=%b bad_cycles=%0d, required 1/0", ack1, bad);
        end
        req1 = 1'b0;
        tick; tick;
        n_checks++;
        if (sccb_sub_address !== 8'h5A || sccb_set_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL change_after_ack: addr=%h data=%h, required 5a/c3", sccb_sub_address, sccb_set_data);
        end
    endtask

    initial begin
        test_reset;
        test_single_port0;
        test_tie;
        test_not_ready;
        test_timeout;
        test_reset_mid;
        test_input_change;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
